// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type, idle-detect FSM states
// and a saturating increment helper for the optional statistics counters.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } idle_state_e;

  // Increment an 8-bit counter, holding at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered head entry (dout/valid). The head
// register is loaded on a push into an empty buffer or on a pop, so a
// pushed byte shows up on dout one cycle after the push edge (no bypass).
// Stored data is not reset; only pointers, count and the head are.
module fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  // Next pointers, occupancy and head entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    rd_next  = rd_ptr_q + 1'b1;
    do_pop   = pop && valid_q;
    // A push into a full buffer is only legal when the head leaves this cycle.
    do_push  = push && ((count_q != CNT_FULL) || do_pop);

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_next;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (do_pop) begin
      // Next head is the following stored entry, or the byte arriving now
      // when the popped head was the only entry.
      if (count_q > CNT_ONE) dout_d = mem_q[rd_next];
      else if (do_push)      dout_d = din;
    end else if (do_push && (count_q == '0)) begin
      dout_d = din;
    end

    valid_d = (count_d != '0);
  end

  // Control and head registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign count = count_q;
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind a Uart8 receiver. Qualifies pushes (framing errors
// discarded, full buffer drops unless a pop frees a slot), keeps a sticky
// overflow flag and raises a one-cycle idleIrq once the line has been quiet
// for IDLE_CYCLES clocks after traffic.
// Handshake: a byte leaves the buffer on a rising clock edge where
// outValid && outReady are both high; outByte/outValid are registered.
// Optional statistics (dropCount/errCount) exist only when the macro
// UART_RX_FIFO_STATS_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = 25000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic                   rxBusy,
  input  byte_t                  rxByte,
  output logic                   outValid,
  input  logic                   outReady,
  output byte_t                  outByte,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clrOverflow,
  output logic                   idleIrq,
`ifdef UART_RX_FIFO_STATS_EN
  output logic [7:0]             dropCount,
  output logic [7:0]             errCount,
`endif
  output idle_state_e            dbgIdleState
);

  localparam int CW = $clog2(IDLE_CYCLES);
  localparam logic [CW-1:0] QUIET_LAST = CW'(IDLE_CYCLES - 1);

  logic        push_req, do_push, do_pop, drop, discard;
  logic        overflow_q, overflow_d;
  idle_state_e state_q, state_d;
  logic [CW-1:0] quiet_q, quiet_d;
  logic        idle_irq_q, idle_irq_d;

  // Push qualification: good bytes go in unless full with no pop this cycle.
  always_comb begin
    push_req = rxDone && !rxErr;
    do_pop   = outValid && outReady;
    do_push  = push_req && (!full || do_pop);
    drop     = push_req && full && !do_pop;
    discard  = rxDone && rxErr;
  end

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (rxByte),
    .dout  (outByte),
    .valid (outValid),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    overflow_d = overflow_q;
    if (clrOverflow) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  // Idle FSM next-state: arm on an accepted push, fire after the quiet run.
  always_comb begin
    state_d    = state_q;
    quiet_d    = quiet_q;
    idle_irq_d = 1'b0;
    case (state_q)
      IDLE: begin
        quiet_d = '0;
        if (do_push) state_d = ARMED;
      end
      ARMED: begin
        if (rxBusy || rxDone) begin
          quiet_d = '0;
        end else if (quiet_q == QUIET_LAST) begin
          quiet_d    = '0;
          state_d    = IDLE;
          idle_irq_d = 1'b1;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        quiet_d = '0;
      end
    endcase
  end

  // Overflow flag and idle FSM registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      quiet_q    <= '0;
      idle_irq_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      state_q    <= state_d;
      quiet_q    <= quiet_d;
      idle_irq_q <= idle_irq_d;
    end
  end

  assign overflow     = overflow_q;
  assign idleIrq      = idle_irq_q;
  assign dbgIdleState = state_q;

`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating drop / framing-error counters.
  always_comb begin
    drop_cnt_d = drop    ? sat_inc8(drop_cnt_q) : drop_cnt_q;
    err_cnt_d  = discard ? sat_inc8(err_cnt_q)  : err_cnt_q;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign dropCount = drop_cnt_q;
  assign errCount  = err_cnt_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule
